// File: rtl/corr_ctrl.sv
// ============================================================================
//  Module   : corr_ctrl
//  Purpose  : Window sequencer for the comp_corr MAC bank. Clears the
//             accumulators, gates sample enables, waits out the MAC pipeline
//             and captures the three sums into held result registers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module corr_ctrl #(
  parameter int DIM_ADD = 64,
  parameter int CNT_W   = 33,
  parameter int MAC_LAT = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [CNT_W-1:0]   nsamples,
  input  logic               abort,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               mac_clr,
  output logic               mac_en,
  input  logic [DIM_ADD-1:0] sum_x2,
  input  logic [DIM_ADD-1:0] sum_xy,
  input  logic [DIM_ADD-1:0] sum_y2,
  output logic [DIM_ADD-1:0] res_x2,
  output logic [DIM_ADD-1:0] res_xy,
  output logic [DIM_ADD-1:0] res_y2,
  output logic               res_valid,
  input  logic               res_ack,
  output logic               busy,
  output logic [CNT_W-1:0]   sample_cnt
);

  // Drain counter only has to reach MAC_LAT-1.
  localparam int                C_DW         = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [C_DW-1:0]   C_DRAIN_LAST = C_DW'(MAC_LAT - 1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_nsamples;
  logic [CNT_W-1:0]   r_cnt;
  logic [C_DW-1:0]    r_drain;
  logic [DIM_ADD-1:0] r_res_x2;
  logic [DIM_ADD-1:0] r_res_xy;
  logic [DIM_ADD-1:0] r_res_y2;
  logic               r_s_ready;
  logic               r_res_valid;
  logic               r_busy;
  logic               w_accept;
  logic               w_last_sample;

  assign w_accept      = s_valid & r_s_ready;
  assign w_last_sample = (r_cnt == (r_nsamples - C_CNT_ONE));

  // Window sequencer; status outputs are registered alongside the state so
  // none of them depends combinationally on start/abort/res_ack.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_nsamples  <= '0;
      r_cnt       <= '0;
      r_drain     <= '0;
      r_res_x2    <= '0;
      r_res_xy    <= '0;
      r_res_y2    <= '0;
      r_s_ready   <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (abort && (r_state != ST_IDLE)) begin
      // Cancel: results and MAC contents are left untouched.
      r_state     <= ST_IDLE;
      r_s_ready   <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // abort alongside start suppresses the start.
          if (start && !abort && (nsamples != '0)) begin
            r_nsamples <= nsamples;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_cnt     <= '0;
          r_s_ready <= 1'b1;
          r_state   <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_cnt <= r_cnt + C_CNT_ONE;
            if (w_last_sample) begin
              r_s_ready <= 1'b0;
              r_drain   <= '0;
              r_state   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain == C_DRAIN_LAST) begin
            // Last product has just reached the sum ports.
            r_res_x2    <= sum_x2;
            r_res_xy    <= sum_xy;
            r_res_y2    <= sum_y2;
            r_res_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        ST_HOLD: begin
          if (res_ack) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_s_ready   <= 1'b0;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // MACs are held clear while in reset as well as during CLEAR.
  assign mac_clr    = clr | (r_state == ST_CLEAR);
  assign mac_en     = w_accept;
  assign s_ready    = r_s_ready;
  assign res_valid  = r_res_valid;
  assign busy       = r_busy;
  assign sample_cnt = r_cnt;
  assign res_x2     = r_res_x2;
  assign res_xy     = r_res_xy;
  assign res_y2     = r_res_y2;

endmodule

`default_nettype wire
